match_core: RTL and testbench

//  Parametrised match/round controller for the fighter game. Sits beside player_core and game_resolver.

---
 rtl/match_core.sv | 277 +++++++++++++++++++++++++++
 tb/tb_match_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_core.sv
// Match/round controller: per-player health lanes plus the IDLE/INTRO/FIGHT/KO/MATCH_OVER
// sequencer that runs the round timer, scores KOs and time-outs and decides the match.

module match_lane #(
   parameter int HP_W   = 8,
   parameter int MAX_HP = 100,
   parameter int DMG_W  = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             apply_i,
   input  logic             hit_i,
   input  logic [DMG_W-1:0] dmg_i,
   output logic [HP_W-1:0]  hp_o
);
   localparam int SW = (HP_W > DMG_W) ? HP_W : DMG_W;

   logic [HP_W-1:0] hp_q, hp_d;
   logic [SW-1:0]   hp_x, dmg_x;

   // Saturating subtract: damage at or above remaining health pins the player at 0.
   always_comb begin
      hp_x  = SW'(hp_q);
      dmg_x = SW'(dmg_i);
      hp_d  = hp_q;
      if (load_i)
         hp_d = HP_W'(MAX_HP);
      else if (apply_i && hit_i)
         hp_d = (dmg_x >= hp_x) ? '0 : HP_W'(hp_x - dmg_x);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) hp_q <= HP_W'(MAX_HP);
      else        hp_q <= hp_d;
   end

   assign hp_o = hp_q;
endmodule

module match_core #(
   parameter int NUM_PLAYERS   = 2,
   parameter int HP_W          = 8,
   parameter int MAX_HP        = 100,
   parameter int DMG_W         = 6,
   parameter int ROUNDS_TO_WIN = 2,
   parameter int MAX_ROUNDS    = 5,
   parameter int ROUND_FRAMES  = 5400,
   parameter int INTRO_FRAMES  = 120,
   parameter int KO_FRAMES     = 180,
   localparam int PID_W        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
   localparam int TMR_W        = $clog2(ROUND_FRAMES + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         SCEN,
   input  logic                         start,
   input  logic [NUM_PLAYERS-1:0]       hit_valid,
   input  logic [NUM_PLAYERS*DMG_W-1:0] hit_dmg,
   output logic [2:0]                   state,
   output logic                         fight_en,
   output logic [NUM_PLAYERS*HP_W-1:0]  hp,
   output logic [NUM_PLAYERS*2-1:0]     wins,
   output logic [TMR_W-1:0]             round_timer,
   output logic [2:0]                   round_num,
   output logic                         ko_pulse,
   output logic                         winner_valid,
   output logic [PID_W-1:0]             winner_id,
   output logic                         match_draw
);
   localparam int PH_MAX = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INTRO = 3'd1,
      S_FIGHT = 3'd2,
      S_KO    = 3'd3,
      S_OVER  = 3'd4
   } state_e;

   typedef struct packed {
      logic             done;
      logic             win;
      logic [PID_W-1:0] id;
   } rnd_res_t;

   state_e                         state_q, state_d;
   logic [PH_W-1:0]                phase_q, phase_d;
   logic [TMR_W-1:0]               timer_q, timer_d;
   logic [NUM_PLAYERS-1:0][1:0]    wins_q, wins_d;
   logic [2:0]                     round_q, round_d;
   logic                           ko_q, ko_d;
   logic                           wv_q, wv_d;
   logic [PID_W-1:0]               wid_q, wid_d;
   logic                           draw_q, draw_d;
   logic                           fen_q, fen_d;
   logic                           hp_load, hp_apply;
   logic [NUM_PLAYERS-1:0][HP_W-1:0] hp_w;

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_lane
      match_lane #(.HP_W(HP_W), .MAX_HP(MAX_HP), .DMG_W(DMG_W)) u_lane (
         .clk     (clk),
         .reset   (reset),
         .load_i  (hp_load),
         .apply_i (hp_apply),
         .hit_i   (hit_valid[g]),
         .dmg_i   (hit_dmg[g*DMG_W +: DMG_W]),
         .hp_o    (hp_w[g])
      );
   end

   logic [2:0]       alive_cnt;
   logic [PID_W-1:0] alive_id, best_id;
   logic [HP_W-1:0]  best_hp;
   logic             best_tie;
   rnd_res_t         rnd;

   // Round scoring on registered health, so a hit is judged one cycle after it lands.
   always_comb begin
      alive_cnt = '0;
      alive_id  = '0;
      best_id   = '0;
      best_hp   = '0;
      best_tie  = 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (hp_w[i] != '0) begin
            alive_cnt = alive_cnt + 3'd1;
            alive_id  = PID_W'(i);
         end
         if (hp_w[i] > best_hp) begin
            best_hp  = hp_w[i];
            best_id  = PID_W'(i);
            best_tie = 1'b0;
         end else if (hp_w[i] == best_hp) begin
            best_tie = 1'b1;
         end
      end
      rnd      = '0;
      rnd.done = (alive_cnt < 3'd2) || (timer_q == '0);
      rnd.win  = (alive_cnt == 3'd1) || ((alive_cnt != 3'd0) && !best_tie);
      rnd.id   = (alive_cnt == 3'd1) ? alive_id : best_id;
   end

   logic             match_won;
   logic [PID_W-1:0] match_id;

   always_comb begin
      match_won = 1'b0;
      match_id  = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (wins_q[i] == 2'(ROUNDS_TO_WIN)) begin
            match_won = 1'b1;
            match_id  = PID_W'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      timer_d  = timer_q;
      wins_d   = wins_q;
      round_d  = round_q;
      ko_d     = 1'b0;
      wv_d     = wv_q;
      wid_d    = wid_q;
      draw_d   = draw_q;
      hp_load  = 1'b0;
      hp_apply = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_INTRO;
               phase_d = '0;
               wins_d  = '0;
               round_d = '0;
               wv_d    = 1'b0;
               draw_d  = 1'b0;
               hp_load = 1'b1;
               timer_d = TMR_W'(ROUND_FRAMES);
            end
         end
         S_INTRO: begin
            if (SCEN) begin
               if (phase_q == PH_W'(INTRO_FRAMES - 1)) begin
                  state_d = S_FIGHT;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
         end
         S_FIGHT: begin
            // The deciding cycle freezes health and timer so KO shows what was scored.
            if (rnd.done) begin
               state_d = S_KO;
               phase_d = '0;
               ko_d    = 1'b1;
               round_d = round_q + 3'd1;
               wv_d    = rnd.win;
               if (rnd.win) begin
                  wins_d[rnd.id] = wins_q[rnd.id] + 2'd1;
                  wid_d          = rnd.id;
               end
            end else begin
               hp_apply = 1'b1;
               if (SCEN && timer_q != '0) timer_d = timer_q - 1'b1;
            end
         end
         S_KO: begin
            if (SCEN) begin
               if (phase_q == PH_W'(KO_FRAMES - 1)) begin
                  phase_d = '0;
                  if (match_won) begin
                     state_d = S_OVER;
                     wv_d    = 1'b1;
                     wid_d   = match_id;
                  end else if (round_q == 3'(MAX_ROUNDS)) begin
                     state_d = S_OVER;
                     draw_d  = 1'b1;
                     wv_d    = 1'b0;
                  end else begin
                     state_d = S_INTRO;
                     hp_load = 1'b1;
                     timer_d = TMR_W'(ROUND_FRAMES);
                  end
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
         end
         S_OVER: begin
            if (start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      fen_d = (state_d == S_FIGHT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         timer_q <= TMR_W'(ROUND_FRAMES);
         wins_q  <= '0;
         round_q <= '0;
         ko_q    <= 1'b0;
         wv_q    <= 1'b0;
         wid_q   <= '0;
         draw_q  <= 1'b0;
         fen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         timer_q <= timer_d;
         wins_q  <= wins_d;
         round_q <= round_d;
         ko_q    <= ko_d;
         wv_q    <= wv_d;
         wid_q   <= wid_d;
         draw_q  <= draw_d;
         fen_q   <= fen_d;
      end
   end

   assign state        = state_q;
   assign fight_en     = fen_q;
   assign hp           = hp_w;
   assign wins         = wins_q;
   assign round_timer  = timer_q;
   assign round_num    = round_q;
   assign ko_pulse     = ko_q;
   assign winner_valid = wv_q;
   assign winner_id    = wid_q;
   assign match_draw   = draw_q;
endmodule

// File: tb/tb_match_core.sv
// Bench for match_core: directed round scenarios plus random hits, all checked every cycle
// against a behavioural match model; literal checks pin the model on the key scenarios.

module tb_match_core;
   localparam int NP = 2, HP_W = 8, DMG_W = 6, MAXHP = 100;
   localparam int RF = 10, INF = 2, KF = 3, RTW = 2, MR = 5;

   logic                  clk = 1'b0, reset = 1'b0, SCEN = 1'b0, start = 1'b0;
   logic [NP-1:0]         hit_valid = '0;
   logic [NP*DMG_W-1:0]   hit_dmg = '0;
   logic [2:0]            state;
   logic                  fight_en;
   logic [NP*HP_W-1:0]    hp;
   logic [NP*2-1:0]       wins;
   logic [3:0]            round_timer;
   logic [2:0]            round_num;
   logic                  ko_pulse, winner_valid, match_draw;
   logic [0:0]            winner_id;

   match_core #(.NUM_PLAYERS(NP), .HP_W(HP_W), .MAX_HP(MAXHP), .DMG_W(DMG_W),
                .ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MR), .ROUND_FRAMES(RF),
                .INTRO_FRAMES(INF), .KO_FRAMES(KF)) dut (
      .clk(clk), .reset(reset), .SCEN(SCEN), .start(start),
      .hit_valid(hit_valid), .hit_dmg(hit_dmg), .state(state), .fight_en(fight_en),
      .hp(hp), .wins(wins), .round_timer(round_timer), .round_num(round_num),
      .ko_pulse(ko_pulse), .winner_valid(winner_valid), .winner_id(winner_id),
      .match_draw(match_draw)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0;
   bit chk_on = 1'b0;

   // Model: 0 IDLE 1 INTRO 2 FIGHT 3 KO 4 MATCH_OVER; ph counts frame ticks in a phase.
   int m_st, m_ph, m_tmr, m_rnd, m_wid;
   int m_hp[NP];
   int m_wins[NP];
   bit m_ko, m_wv, m_draw;

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic void m_reset();
      m_st = 0; m_ph = 0; m_tmr = RF; m_rnd = 0; m_wid = 0;
      m_ko = 0; m_wv = 0; m_draw = 0;
      for (int i = 0; i < NP; i++) begin m_hp[i] = MAXHP; m_wins[i] = 0; end
   endfunction

   function automatic void m_new_round();
      m_tmr = RF;
      for (int i = 0; i < NP; i++) m_hp[i] = MAXHP;
   endfunction

   function automatic void model_step(bit sc, bit st, logic [NP-1:0] hv, logic [NP*DMG_W-1:0] dm);
      int alive, aid, mx, nmx, w;
      bit fin, win;
      m_ko = 0;
      case (m_st)
         0: if (st) begin
            m_st = 1; m_ph = 0; m_rnd = 0; m_wv = 0; m_draw = 0;
            for (int i = 0; i < NP; i++) m_wins[i] = 0;
            m_new_round();
         end
         1: if (sc) begin
            m_ph++;
            if (m_ph == INF) begin m_st = 2; m_ph = 0; end
         end
         2: begin
            alive = 0; aid = 0; mx = -1; nmx = 0; w = 0;
            for (int i = 0; i < NP; i++) begin
               if (m_hp[i] > 0) begin alive++; aid = i; end
               if (m_hp[i] > mx) begin mx = m_hp[i]; w = i; nmx = 1; end
               else if (m_hp[i] == mx) nmx++;
            end
            fin = 0; win = 0;
            if (alive == 0) fin = 1;
            else if (alive == 1) begin fin = 1; win = 1; w = aid; end
            else if (m_tmr == 0) begin fin = 1; win = (nmx == 1); end
            if (fin) begin
               m_st = 3; m_ph = 0; m_ko = 1; m_rnd++; m_wv = win;
               if (win) begin m_wins[w]++; m_wid = w; end
            end else begin
               for (int i = 0; i < NP; i++)
                  if (hv[i]) begin
                     m_hp[i] = m_hp[i] - int'(dm[i*DMG_W +: DMG_W]);
                     if (m_hp[i] < 0) m_hp[i] = 0;
                  end
               if (sc && m_tmr > 0) m_tmr--;
            end
         end
         3: if (sc) begin
            m_ph++;
            if (m_ph == KF) begin
               m_ph = 0; w = -1;
               for (int i = 0; i < NP; i++) if (m_wins[i] == RTW) w = i;
               if (w >= 0) begin m_st = 4; m_wv = 1; m_wid = w; end
               else if (m_rnd == MR) begin m_st = 4; m_draw = 1; m_wv = 0; end
               else begin m_st = 1; m_new_round(); end
            end
         end
         default: if (st) m_st = 0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk("state", int'(state), m_st);
         chk("fight_en", int'(fight_en), int'(m_st == 2));
         for (int i = 0; i < NP; i++) begin
            chk($sformatf("hp%0d", i), int'(hp[i*HP_W +: HP_W]), m_hp[i]);
            chk($sformatf("wins%0d", i), int'(wins[i*2 +: 2]), m_wins[i]);
         end
         chk("round_timer", int'(round_timer), m_tmr);
         chk("round_num", int'(round_num), m_rnd);
         chk("ko_pulse", int'(ko_pulse), int'(m_ko));
         chk("winner_valid", int'(winner_valid), int'(m_wv));
         chk("winner_id", int'(winner_id), m_wid);
         chk("match_draw", int'(match_draw), int'(m_draw));
      end
   end

   function automatic logic [NP*DMG_W-1:0] dd(int a, int b);
      return {6'(b), 6'(a)};
   endfunction

   // SCEN fires every fourth cycle throughout.
   task automatic step(bit st, logic [NP-1:0] hv, logic [NP*DMG_W-1:0] dm);
      bit sc;
      sc = (cyc % 4 == 0);
      cyc++;
      SCEN = sc; start = st; hit_valid = hv; hit_dmg = dm;
      @(posedge clk);
      model_step(sc, st, hv, dm);
      #1;
      SCEN = 1'b0; start = 1'b0; hit_valid = '0; hit_dmg = '0;
   endtask

   task automatic run_until(int tgt, int bound, string nm);
      int n;
      n = 0;
      while (int'(state) != tgt && n < bound) begin
         step(1'b0, '0, '0);
         n++;
      end
      chk(nm, int'(state), tgt);
   endtask

   initial begin
      logic [NP-1:0] hv;
      m_reset();
      chk_on = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", int'(state), 0);
      chk("rst_hp0", int'(hp[7:0]), 100);
      chk("rst_tmr", int'(round_timer), 10);
      chk("rst_wins", int'(wins), 0);
      reset = 1'b1;

      step(1'b1, '0, '0);
      run_until(2, 50, "t1_fight");
      chk("t1_fen", int'(fight_en), 1);
      chk("t1_hp0", int'(hp[7:0]), 100);
      chk("t1_hp1", int'(hp[15:8]), 100);
      chk("t1_tmr", int'(round_timer), 10);

      step(1'b0, 2'b01, dd(60, 0));
      chk("t2_hp0a", int'(hp[7:0]), 40);
      step(1'b0, 2'b01, dd(60, 0));
      chk("t2_hp0b", int'(hp[7:0]), 0);
      step(1'b0, '0, '0);
      chk("t2_state", int'(state), 3);
      chk("t2_ko", int'(ko_pulse), 1);
      chk("t2_wins1", int'(wins[3:2]), 1);
      chk("t2_wid", int'(winner_id), 1);
      chk("t2_model_wins1", m_wins[1], 1);
      step(1'b0, '0, '0);
      chk("t2_ko_off", int'(ko_pulse), 0);

      run_until(2, 100, "t3_fight");
      step(1'b0, 2'b11, dd(50, 50));
      step(1'b0, 2'b11, dd(63, 63));
      chk("t3_hp", int'(hp), 0);
      step(1'b0, '0, '0);
      chk("t3_state", int'(state), 3);
      chk("t3_wv", int'(winner_valid), 0);
      chk("t3_wins", int'(wins), 4);
      chk("t3_model_wv", int'(m_wv), 0);

      run_until(2, 100, "t4_fight");
      step(1'b0, 2'b11, dd(10, 20));
      chk("t4_hp0", int'(hp[7:0]), 90);
      chk("t4_hp1", int'(hp[15:8]), 80);
      run_until(3, 200, "t4_ko");
      chk("t4_wid", int'(winner_id), 0);
      chk("t4_wv", int'(winner_valid), 1);
      chk("t4_tmr", int'(round_timer), 0);
      run_until(2, 100, "t4b_fight");
      run_until(3, 200, "t4b_ko");
      chk("t4b_wv", int'(winner_valid), 0);
      chk("t4b_wins", int'(wins), 5);
      chk("t4b_round", int'(round_num), 4);

      run_until(2, 100, "t5_fight");
      step(1'b0, 2'b01, dd(63, 0));
      step(1'b0, 2'b01, dd(37, 0));
      run_until(4, 100, "t5_over");
      chk("t5_wins1", int'(wins[3:2]), 2);
      chk("t5_wv", int'(winner_valid), 1);
      chk("t5_wid", int'(winner_id), 1);
      step(1'b1, '0, '0);
      chk("t5_idle", int'(state), 0);

      step(1'b1, '0, '0);
      for (int r = 0; r < 5; r++) begin
         run_until(2, 100, "t6_fight");
         step(1'b0, 2'b11, dd(63, 63));
         step(1'b0, 2'b11, dd(63, 63));
         step(1'b0, '0, '0);
         chk("t6_ko", int'(ko_pulse), 1);
      end
      run_until(4, 100, "t6_over");
      chk("t6_draw", int'(match_draw), 1);
      chk("t6_wv", int'(winner_valid), 0);
      chk("t6_round", int'(round_num), 5);
      chk("t6_model_draw", int'(m_draw), 1);

      repeat (3000) begin
         for (int i = 0; i < NP; i++) hv[i] = ($urandom_range(0, 3) == 0);
         step($urandom_range(0, 15) == 0, hv, (NP*DMG_W)'($urandom));
      end

      reset = 1'b0; m_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      step(1'b1, '0, '0);
      run_until(2, 50, "t7_fight");
      step(1'b0, 2'b01, dd(30, 0));
      chk("t7_hp0", int'(hp[7:0]), 70);
      reset = 1'b0; m_reset();
      #1;
      chk("t7_state", int'(state), 0);
      chk("t7_hp0_rst", int'(hp[7:0]), 100);
      chk("t7_tmr", int'(round_timer), 10);
      chk("t7_ko", int'(ko_pulse), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (4) step(1'b0, '0, '0);

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
